// File: rtl/pc_next_unit.sv
// Fetch-stage PC register and next-PC sequencer (BOOT/RUN/HALT FSM, imem valid/ready).
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_next_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    input  logic        halt,
    input  logic        resume,
    output logic [31:0] PC,
    output logic [31:0] PC_plus4,
    output logic        pc_valid,
    output logic [31:0] fetch_count,
    output logic        misalign
);

`ifdef PC_ALIGN_CHECK_EN
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT, S_TRAP} state_t;
`else
    typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;
`endif

    state_t      state, state_nxt;
    logic [31:0] pc_nxt;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        accept;
    logic        trap_hit;

    assign PC_plus4        = PC + 32'd4;
    assign accept          = pc_valid & fetch_ready;
    assign redirect        = jump_valid | branch_taken;
    assign redirect_target = jump_valid ? jump_target : branch_target;

    always_comb begin
        state_nxt = state;
        pc_nxt    = PC;
        trap_hit  = 1'b0;
        case (state)
            S_BOOT: state_nxt = S_RUN;
            S_RUN: begin
                if (redirect) begin
`ifdef PC_ALIGN_CHECK_EN
                    if (redirect_target[1:0] != 2'b00) trap_hit = 1'b1;
                    else                               pc_nxt   = redirect_target;
`else
                    pc_nxt = {redirect_target[31:2], 2'b00};
`endif
                end else if (accept) begin
                    pc_nxt = PC_plus4;
                end
                if (halt) state_nxt = S_HALT;
`ifdef PC_ALIGN_CHECK_EN
                // A trap overrides both the target load and a simultaneous halt.
                if (trap_hit) begin
                    state_nxt = S_TRAP;
                    pc_nxt    = TRAP_VECTOR;
                end
`endif
            end
            S_HALT: if (resume && !halt) state_nxt = S_RUN;
`ifdef PC_ALIGN_CHECK_EN
            S_TRAP: state_nxt = S_TRAP;
`endif
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_BOOT;
            PC          <= RESET_VECTOR;
            pc_valid    <= 1'b0;
            fetch_count <= 32'd0;
        end else begin
            state    <= state_nxt;
            PC       <= pc_nxt;
            pc_valid <= (state_nxt == S_RUN);
            if (accept) fetch_count <= fetch_count + 32'd1;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        misalign <= 1'b0;
        else if (trap_hit) misalign <= 1'b1;
    end
`else
    logic unused_bits;
    assign unused_bits = ^{trap_hit, redirect_target[1:0], TRAP_VECTOR};
    assign misalign    = 1'b0;
`endif

endmodule

// File: tb/tb_pc_next_unit.sv
// Scoreboard bench for pc_next_unit: directed scenarios then random traffic vs a behavioural model.
module tb_pc_next_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_ready = 1'b0, branch_taken = 1'b0, jump_valid = 1'b0;
    logic        halt = 1'b0, resume = 1'b0;
    logic [31:0] branch_target = '0, jump_target = '0;
    logic [31:0] PC, PC_plus4, fetch_count;
    logic        pc_valid, misalign;

    pc_next_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_valid(jump_valid), .jump_target(jump_target),
        .halt(halt), .resume(resume), .PC(PC), .PC_plus4(PC_plus4),
        .pc_valid(pc_valid), .fetch_count(fetch_count), .misalign(misalign)
    );

    always #5 clk = ~clk;

`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic        v;
        logic [31:0] cnt;
        logic        mis;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model: mode is a plain name, PC and counter are plain integers.
    string       m_mode = "BOOT";
    logic [31:0] m_pc   = 32'h0;
    logic [31:0] m_cnt  = 32'h0;
    logic        m_mis  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = "BOOT"; m_pc = 32'h0; m_cnt = 32'h0; m_mis = 1'b0;
    endtask

    // Drive one cycle of inputs at the falling edge and queue what the next rising edge must produce.
    task automatic step(input bit rst, input bit fr, input bit bt, input logic [31:0] btgt,
                        input bit jv, input logic [31:0] jt, input bit h, input bit r);
        exp_t        e;
        logic [31:0] tgt;
        @(negedge clk);
        rst_n = rst; fetch_ready = fr; branch_taken = bt; branch_target = btgt;
        jump_valid = jv; jump_target = jt; halt = h; resume = r;
        if (!rst) begin
            model_reset();
        end else begin
            if (m_mode == "RUN" && fr) m_cnt = m_cnt + 1;
            if (m_mode == "BOOT") begin
                m_mode = "RUN";
            end else if (m_mode == "RUN") begin
                tgt = jv ? jt : btgt;
                if (jv || bt) begin
                    if (ALIGN_CHK && (tgt % 4 != 0)) begin
                        m_pc = 32'h80; m_mis = 1'b1;
                    end else begin
                        m_pc = tgt - (tgt % 4);
                    end
                end else if (fr) begin
                    m_pc = m_pc + 4;
                end
                if (m_mis) m_mode = "TRAP";
                else if (h) m_mode = "HALT";
            end else if (m_mode == "HALT") begin
                if (r && !h) m_mode = "RUN";
            end
        end
        e.pc = m_pc; e.v = (m_mode == "RUN"); e.cnt = m_cnt; e.mis = m_mis;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", PC, e.pc);
            chk("pc_plus4", PC_plus4, e.pc + 32'd4);
            chk("pc_valid", {31'd0, pc_valid}, {31'd0, e.v});
            chk("fetch_count", fetch_count, e.cnt);
            chk("misalign", {31'd0, misalign}, {31'd0, e.mis});
        end
    end

    initial begin
        // Reset state
        step(0, 1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        // 1: boot then three accepts -> PC 0,4,8,C, count 3
        repeat (4) step(1, 1, 0, 0, 0, 0, 0, 0);
        // 2: reach 0x10, branch with fetch_ready low
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 1, 32'h40, 0, 0, 0, 0);
        // 3: jump beats branch
        step(1, 0, 1, 32'h40, 1, 32'h200, 0, 0);
        // 4: wrap at top of address space
        step(1, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        // 5: branch + halt, branch while halted ignored, resume
        step(1, 1, 1, 32'h80, 0, 0, 1, 0);
        step(1, 1, 1, 32'h300, 0, 0, 0, 0);
        step(1, 1, 0, 0, 1, 32'h400, 1, 1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        // 6: misaligned jump
        step(1, 1, 0, 0, 1, 32'h102, 0, 0);
        repeat (3) step(1, 1, 0, 0, 1, 32'h500, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional synchronous-to-stimulus resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] bt_t, jt_t;
            bt_t = $urandom;
            jt_t = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                bt_t[1:0] = 2'b00;
                jt_t[1:0] = 2'b00;
            end
            step($urandom_range(0, 99) != 0,
                 $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, bt_t,
                 $urandom_range(0, 9) == 0, jt_t,
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset asserted mid-cycle takes effect immediately.
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc", PC, 32'h0);
        chk("async_valid", {31'd0, pc_valid}, 32'd0);
        chk("async_count", fetch_count, 32'd0);
        model_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
